// File: rtl/sctag_dir_req_seq_if.sv
// Request/response bundle between a C3 directory requester and
// the sequencer that produces the registered C4 control set.
interface sctag_dir_req_seq_if;
  logic       lkup_req_c3;
  logic [3:0] lkup_panel_c3;
  logic [7:0] inval_mask_c3;
  logic       rd_req_c3;
  logic       wr_req_c3;
  logic [1:0] rd_panel_c3;
  logic [1:0] wr_panel_c3;
  logic [5:0] rd_entry_c3;
  logic [5:0] wr_entry_c3;
  logic       warm_clr_req;
  logic       dir_stall_c3;
  logic [3:0] lkup_en_c4_buf;
  logic [7:0] inval_mask_c4_buf;
  logic [3:0] rw_dec_c4_buf;
  logic       rd_en_c4_buf;
  logic       wr_en_c4_buf;
  logic [5:0] rw_entry_c4_buf;
  logic       dir_clear_c4_buf;
  logic       clr_busy;
  logic       clr_done;

  modport master (
    output lkup_req_c3, lkup_panel_c3, inval_mask_c3,
    output rd_req_c3, wr_req_c3,
    output rd_panel_c3, wr_panel_c3,
    output rd_entry_c3, wr_entry_c3,
    output warm_clr_req,
    input  dir_stall_c3,
    input  lkup_en_c4_buf, inval_mask_c4_buf,
    input  rw_dec_c4_buf, rd_en_c4_buf, wr_en_c4_buf,
    input  rw_entry_c4_buf, dir_clear_c4_buf,
    input  clr_busy, clr_done
  );

  modport slave (
    input  lkup_req_c3, lkup_panel_c3, inval_mask_c3,
    input  rd_req_c3, wr_req_c3,
    input  rd_panel_c3, wr_panel_c3,
    input  rd_entry_c3, wr_entry_c3,
    input  warm_clr_req,
    output dir_stall_c3,
    output lkup_en_c4_buf, inval_mask_c4_buf,
    output rw_dec_c4_buf, rd_en_c4_buf, wr_en_c4_buf,
    output rw_entry_c4_buf, dir_clear_c4_buf,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/sctag_dir_req_seq.sv
// L2 tag directory request sequencer: C3 decode into registered
// C4 controls, one-entry read skid and warm-clear sweep.
module sctag_dir_req_seq #(
  parameter int NENT = 64
) (
  input logic              rclk,
  input logic              arst_l,
  sctag_dir_req_seq_if.slave dir
);

  localparam int unsigned LAST = NENT - 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       clr_pend_q, clr_pend_d;
  logic       clr_busy_q, clr_busy_d;
  logic       clr_done_q, clr_done_d;

  logic       skid_full_q, skid_full_d;
  logic [1:0] skid_panel_q, skid_panel_d;
  logic [5:0] skid_entry_q, skid_entry_d;

  logic [3:0] lkup_en_q, lkup_en_d;
  logic [7:0] inval_q, inval_d;
  logic [3:0] rw_dec_q, rw_dec_d;
  logic       rd_en_q, rd_en_d;
  logic       wr_en_q, wr_en_d;
  logic [5:0] rw_entry_q, rw_entry_d;
  logic       dir_clr_q, dir_clr_d;

  logic stall;
  logic lkup_v, rd_v, wr_v;
  logic accept;

  assign stall  = skid_full_q | (state_q != IDLE) | clr_pend_q;
  assign lkup_v = dir.lkup_req_c3 & ~stall;
  assign rd_v   = dir.rd_req_c3 & ~stall;
  assign wr_v   = dir.wr_req_c3 & ~stall;
  assign accept = dir.warm_clr_req & (state_q == IDLE) & ~clr_pend_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_pend_q) state_d = skid_full_q ? DRAIN : CLEAR;
      end
      DRAIN: begin
        if (!skid_full_q) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(LAST)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    clr_pend_d = clr_pend_q | accept;
    if (state_d == CLEAR) clr_pend_d = 1'b0;
    clr_busy_d = clr_pend_d | (state_d != IDLE);
    clr_done_d = (state_d == DONE);
  end

  // Skid only ever holds the read that lost a same-cycle collision.
  always_comb begin
    skid_full_d  = ~skid_full_q & rd_v & wr_v;
    skid_panel_d = skid_panel_q;
    skid_entry_d = skid_entry_q;
    if (rd_v & wr_v) begin
      skid_panel_d = dir.rd_panel_c3;
      skid_entry_d = dir.rd_entry_c3;
    end
  end

  always_comb begin
    lkup_en_d  = '0;
    inval_d    = '0;
    rw_dec_d   = '0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    rw_entry_d = '0;
    dir_clr_d  = 1'b0;
    if (state_d == CLEAR) begin
      dir_clr_d  = 1'b1;
      rw_dec_d   = 4'hF;
      rw_entry_d = cnt_d;
    end else begin
      if (lkup_v) begin
        lkup_en_d = dir.lkup_panel_c3;
        inval_d   = dir.inval_mask_c3;
      end
      priority case (1'b1)
        skid_full_q: begin
          rd_en_d    = 1'b1;
          rw_dec_d   = 4'b0001 << skid_panel_q;
          rw_entry_d = skid_entry_q;
        end
        wr_v: begin
          wr_en_d    = 1'b1;
          rw_dec_d   = 4'b0001 << dir.wr_panel_c3;
          rw_entry_d = dir.wr_entry_c3;
        end
        rd_v: begin
          rd_en_d    = 1'b1;
          rw_dec_d   = 4'b0001 << dir.rd_panel_c3;
          rw_entry_d = dir.rd_entry_c3;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_pend_q   <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_panel_q <= '0;
      skid_entry_q <= '0;
      lkup_en_q    <= '0;
      inval_q      <= '0;
      rw_dec_q     <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rw_entry_q   <= '0;
      dir_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_pend_q   <= clr_pend_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      skid_full_q  <= skid_full_d;
      skid_panel_q <= skid_panel_d;
      skid_entry_q <= skid_entry_d;
      lkup_en_q    <= lkup_en_d;
      inval_q      <= inval_d;
      rw_dec_q     <= rw_dec_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      rw_entry_q   <= rw_entry_d;
      dir_clr_q    <= dir_clr_d;
    end
  end

  assign dir.dir_stall_c3      = stall;
  assign dir.lkup_en_c4_buf    = lkup_en_q;
  assign dir.inval_mask_c4_buf = inval_q;
  assign dir.rw_dec_c4_buf     = rw_dec_q;
  assign dir.rd_en_c4_buf      = rd_en_q;
  assign dir.wr_en_c4_buf      = wr_en_q;
  assign dir.rw_entry_c4_buf   = rw_entry_q;
  assign dir.dir_clear_c4_buf  = dir_clr_q;
  assign dir.clr_busy          = clr_busy_q;
  assign dir.clr_done          = clr_done_q;

endmodule

// File: tb/tb_sctag_dir_req_seq.sv
// Directed bench for sctag_dir_req_seq with hand-computed
// expectations for issue, collision, sweep and reset cases.
module tb_sctag_dir_req_seq;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  sctag_dir_req_seq_if dif ();

  sctag_dir_req_seq #(.NENT(64)) dut (
    .rclk   (clk),
    .arst_l (rst_n),
    .dir    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    dif.lkup_req_c3   = 1'b0;
    dif.lkup_panel_c3 = '0;
    dif.inval_mask_c3 = '0;
    dif.rd_req_c3     = 1'b0;
    dif.wr_req_c3     = 1'b0;
    dif.rd_panel_c3   = '0;
    dif.wr_panel_c3   = '0;
    dif.rd_entry_c3   = '0;
    dif.wr_entry_c3   = '0;
    dif.warm_clr_req  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_rd(input logic [1:0] p,
                        input logic [5:0] e);
    dif.rd_req_c3   = 1'b1;
    dif.rd_panel_c3 = p;
    dif.rd_entry_c3 = e;
  endtask

  task automatic drv_wr(input logic [1:0] p,
                        input logic [5:0] e);
    dif.wr_req_c3   = 1'b1;
    dif.wr_panel_c3 = p;
    dif.wr_entry_c3 = e;
  endtask

  function automatic logic [31:0] all_out();
    return {4'h0,
            dif.lkup_en_c4_buf, dif.inval_mask_c4_buf,
            dif.rw_dec_c4_buf, dif.rd_en_c4_buf,
            dif.wr_en_c4_buf, dif.rw_entry_c4_buf,
            dif.dir_clear_c4_buf, dif.clr_busy,
            dif.clr_done, dif.dir_stall_c3};
  endfunction

  function automatic logic [31:0] rw_vec();
    return {20'h0, dif.rd_en_c4_buf, dif.wr_en_c4_buf,
            dif.rw_dec_c4_buf, dif.rw_entry_c4_buf};
  endfunction

  function automatic logic [31:0] ctl_vec();
    return {29'h0, dif.clr_busy, dif.dir_stall_c3,
            dif.clr_done};
  endfunction

  function automatic logic [31:0] clr_vec();
    return {7'h0, dif.dir_clear_c4_buf,
            dif.rw_dec_c4_buf, dif.rw_entry_c4_buf,
            dif.rd_en_c4_buf, dif.wr_en_c4_buf,
            dif.lkup_en_c4_buf, dif.inval_mask_c4_buf};
  endfunction

  // Called in the cycle before the first swept entry is visible.
  task automatic run_sweep(input bit poke);
    logic [5:0] e;
    for (int i = 0; i < 64; i++) begin
      step();
      if (poke && i == 9) idle_in();
      if (poke && i == 29) idle_in();
      e = 6'(i);
      chk("sweep_ent", clr_vec(),
          {7'h0, 1'b1, 4'hF, e, 2'b00, 4'h0, 8'h00});
      chk("sweep_ctl", ctl_vec(), 32'b110);
      if (poke && i == 8) begin
        drv_rd(2'd1, 6'd7);
        drv_wr(2'd2, 6'd8);
        dif.lkup_req_c3   = 1'b1;
        dif.lkup_panel_c3 = 4'hF;
      end
      if (poke && i == 28) dif.warm_clr_req = 1'b1;
    end
    step();
    chk("done_ctl", ctl_vec(), 32'b111);
    chk("done_clr", {31'h0, dif.dir_clear_c4_buf}, 32'h0);
    step();
    chk("post_ctl", ctl_vec(), 32'b000);
    chk("post_rw", rw_vec(), 32'h0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    idle_in();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_all", all_out(), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    chk("rst_idle", all_out(), 32'h0);

    // write issue
    drv_wr(2'd2, 6'h2A);
    step();
    idle_in();
    chk("wr_issue", rw_vec(), {20'h0, 2'b01, 4'b0100, 6'h2A});
    chk("wr_stall", {31'h0, dif.dir_stall_c3}, 32'h0);

    // non-colliding read
    drv_rd(2'd3, 6'h3F);
    step();
    idle_in();
    chk("rd_issue", rw_vec(), {20'h0, 2'b10, 4'b1000, 6'h3F});

    // collision, with an illegal write offered during the stall
    drv_rd(2'd1, 6'd5);
    drv_wr(2'd3, 6'd9);
    step();
    idle_in();
    chk("col_wr", rw_vec(), {20'h0, 2'b01, 4'b1000, 6'd9});
    chk("col_stall1", {31'h0, dif.dir_stall_c3}, 32'h1);
    drv_wr(2'd0, 6'd33);
    step();
    idle_in();
    chk("col_rd", rw_vec(), {20'h0, 2'b10, 4'b0010, 6'd5});
    chk("col_stall2", {31'h0, dif.dir_stall_c3}, 32'h0);
    step();
    chk("col_quiet", rw_vec(), 32'h0);

    // lookup together with a write
    dif.lkup_req_c3   = 1'b1;
    dif.lkup_panel_c3 = 4'b0011;
    dif.inval_mask_c3 = 8'hA5;
    drv_wr(2'd0, 6'd1);
    step();
    idle_in();
    chk("lk_en", {28'h0, dif.lkup_en_c4_buf}, 32'h3);
    chk("lk_inval", {24'h0, dif.inval_mask_c4_buf}, 32'hA5);
    chk("lk_wr", rw_vec(), {20'h0, 2'b01, 4'b0001, 6'd1});
    step();
    chk("lk_clear", {20'h0, dif.lkup_en_c4_buf,
                     dif.inval_mask_c4_buf}, 32'h0);

    // warm clear sweep, skid empty
    dif.warm_clr_req = 1'b1;
    step();
    idle_in();
    chk("clr_t1_ctl", ctl_vec(), 32'b110);
    chk("clr_t1_clr", {31'h0, dif.dir_clear_c4_buf}, 32'h0);
    run_sweep(1'b1);
    step();
    chk("clr_noside", all_out(), 32'h0);

    // warm clear in the same cycle as a collision
    drv_rd(2'd1, 6'd5);
    drv_wr(2'd3, 6'd9);
    dif.warm_clr_req = 1'b1;
    step();
    idle_in();
    chk("cc_wr", rw_vec(), {20'h0, 2'b01, 4'b1000, 6'd9});
    chk("cc_ctl1", ctl_vec(), 32'b110);
    step();
    chk("cc_rd", rw_vec(), {20'h0, 2'b10, 4'b0010, 6'd5});
    chk("cc_nclr", {31'h0, dif.dir_clear_c4_buf}, 32'h0);
    chk("cc_ctl2", ctl_vec(), 32'b110);
    run_sweep(1'b0);

    // reset in the middle of a sweep
    dif.warm_clr_req = 1'b1;
    step();
    idle_in();
    repeat (21) step();
    chk("mid_ent", clr_vec(),
        {7'h0, 1'b1, 4'hF, 6'd20, 2'b00, 4'h0, 8'h00});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", all_out(), 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_idle", all_out(), 32'h0);
    end
    drv_wr(2'd1, 6'd17);
    step();
    idle_in();
    chk("mid_wr", rw_vec(), {20'h0, 2'b01, 4'b0010, 6'd17});
    chk("mid_ctl", ctl_vec(), 32'b000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sctag_dir_req_seq.md
# sctag_dir_req_seq

Directory request sequencer for one L2 tag slice: accepts C3 directory lookup/read/write requests and warm-reset clear requests, and produces the registered C4 `*_c4_buf` control bundle consumed by the directory control stage. It serialises same-cycle read/write collisions through a one-entry skid buffer, and runs a 64-entry warm-clear sweep. While the sweep runs, functional requests are stalled.

## Interface
- `NENT`, 64: directory entries per panel. The sweep count is `NENT`; the entry index width is 6.
- `rclk` in 1: clock.
- `arst_l` in 1: asynchronous active-low reset.
- `lkup_req_c3` in 1: CAM lookup request.
- `lkup_panel_c3` in 4: panels to CAM. Bit order is 0 leftTop, 1 rightTop, 2 leftBottom, 3 rightBottom.
- `inval_mask_c3` in 8: invalidate mask accompanying a lookup.
- `rd_req_c3` in 1: directory entry read request.
- `wr_req_c3` in 1: directory entry write request.
- `rd_panel_c3`, `wr_panel_c3` in 2 each: encoded target panel.
- `rd_entry_c3`, `wr_entry_c3` in 6 each: target entry.
- `warm_clr_req` in 1: single-cycle pulse requesting a full directory valid-bit clear.
- `dir_stall_c3` out 1: combinational. When 1, the requester must not present `lkup`/`rd`/`wr` requests.
- `lkup_en_c4_buf` out 4: registered.
- `inval_mask_c4_buf` out 8: registered.
- `rw_dec_c4_buf` out 4: registered; one-hot, or 4'hF during clear.
- `rd_en_c4_buf` out 1: registered.
- `wr_en_c4_buf` out 1: registered.
- `rw_entry_c4_buf` out 6: registered.
- `dir_clear_c4_buf` out 1: registered.
- `clr_busy` out 1: registered; high from sweep acceptance until the `clr_done` cycle, inclusive.
- `clr_done` out 1: registered one-cycle pulse after the last swept entry.

## Operation
- **Registered outputs:** all `*_c4_buf` outputs are flops loaded every cycle from C3 decode.
- **Reset values:** every output is 0, the FSM is IDLE, the skid buffer is empty, the counter is 0 and the pending-clear flag is 0.
- **Lookup path:** `lkup_en_c4_buf = lkup_req_c3 ? lkup_panel_c3 : 0`. `inval_mask_c4_buf` takes `inval_mask_c3` when `lkup_req_c3` is set, else 0. Lookups proceed in the same cycle as a read or write.
- **Read/write path:** C4 carries at most one of `rd_en`/`wr_en`. `rw_dec_c4_buf` is the one-hot decode of the issued panel, and `rw_entry_c4_buf` is the issued entry.
- **Priority, highest first:** skid buffer read, then C3 write, then C3 read.
- **Collision cases:**
  - `rd_req_c3` and `wr_req_c3` in the same cycle: the write issues and the read (panel, entry) loads into the skid buffer.
  - Skid buffer full with a new C3 write (requester violation): the skid read issues and the write is dropped.
- **Skid buffer:** one entry. It drains on the cycle after it loads.
- **Stall:** `dir_stall_c3 = skid_full | (state != IDLE) | clr_pend`. Requests presented while stall=1 are ignored with no side effect.
- **Clear FSM states:** IDLE, DRAIN, CLEAR, DONE.
  - **IDLE:** `warm_clr_req` sets `clr_pend`. The next cycle moves to DRAIN if the skid buffer is full, else to CLEAR. `clr_busy` rises with the transition.
  - **DRAIN:** waits for the skid buffer to empty, then moves to CLEAR.
  - **CLEAR:** for counts 0..NENT-1, issues one entry per cycle:
    - `dir_clear_c4_buf=1`, `rw_dec_c4_buf=4'hF`, `rw_entry_c4_buf=count`;
    - `rd_en`, `wr_en`, `lkup_en` and `inval_mask` are 0.
    - After count NENT-1, moves to DONE and the counter wraps to 0.
  - **DONE:** one cycle. `clr_done=1` on the registered output, `clr_busy` drops the cycle after, then IDLE. `clr_pend` clears on entry to CLEAR.
- **Late clear requests:** `warm_clr_req` while `clr_pend`, DRAIN, CLEAR or DONE is ignored; it is not queued.
- **Simultaneous clear and request:** a `warm_clr_req` in the same cycle as a C3 request lets that request issue normally; the sweep starts afterwards.
- **Reset mid-sweep:** `arst_l` low aborts immediately. All outputs go to 0 asynchronously and no `clr_done` is produced.

## Timing
- **C3 to C4 latency:** 1 cycle for lookup, write and non-colliding read.
- **Colliding read:** issues 2 cycles after C3. `dir_stall_c3` is high for exactly one cycle, the cycle after the collision.
- **Clear sweep, with `warm_clr_req` at cycle T and skid buffer empty:**
  - `clr_busy` is 1 at T+1.
  - `dir_clear_c4_buf` is 1 from T+2 through T+65, with entries 0..63.
  - `clr_done` is 1 at T+66.
  - `clr_busy` is 0 and stall drops at T+67.
- **Stall window:** `dir_stall_c3` is high from T+1 through T+66.
- **Clear with skid buffer full at T:** each phase shifts by one cycle.

## Test plan
- **Reset:** with `arst_l` low, check all outputs are 0. After release, with no requests, outputs stay 0.
- **Write issue:** `wr_req` with panel 2, entry 6'h2A at cycle T. At T+1 expect `wr_en_c4_buf=1`, `rw_dec=4'b0100`, `rw_entry=6'h2A`, `rd_en=0`.
- **Read/write collision:** `rd` (panel 1, entry 5) and `wr` (panel 3, entry 9) at T. Expect:
  - T+1: write, `rw_dec=4'b1000`, `rw_entry=9`, and `dir_stall_c3=1`.
  - T+2: read, `rw_dec=4'b0010`, `rw_entry=5`.
  - Stall low by T+2.
- **Lookup with write:** lookup (panel mask 4'b0011, inval 8'hA5) together with a write at T. At T+1 expect `lkup_en=4'b0011`, `inval_mask=8'hA5`, and the write also issued.
- **Warm clear sweep:** `warm_clr_req` at T. Check the 64 consecutive `dir_clear` cycles with entries 0..63 and `rw_dec=4'hF`, `clr_done` at T+66, and that a request presented at T+10 is ignored. Also send a clear issued in the same cycle as a collision: the sweep must wait for the drain.
- **Reset mid-sweep:** assert `arst_l` low at count 20. Expect all outputs 0 immediately, no `clr_done`, and IDLE after release.
